operand_fetch: RTL and testbench

- Operand-fetch stage sitting directly upstream of the 32-bit register file.
- Accepts one decoded instruction at a time from decode and checks source registers against a register scoreboard.
- Drives register-file read ports 1-3, captures the returned operands and CPSR, and presents an operand bundle to execute over a valid/ready handshake.
- Tracks in-flight destination writes; writeback clears scoreboard entries.

---
 rtl/operand_fetch_pkg.sv | 43 ++++
 rtl/operand_fetch_reg_scoreboard.sv | 40 ++++
 rtl/operand_fetch.sv | 183 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants, FSM encoding and decode-bundle layout for the operand-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package operand_fetch_pkg;

    localparam int N       = 32;   // register data width
    localparam int AW      = 4;    // register address width
    localparam int CTRL_W  = 16;   // opaque control word width
    localparam int REG_PC  = 15;   // R15 is the PC, hazard-checked like any register
    localparam int SB_CPSR = 16;   // scoreboard bit tracking the CPSR
    localparam int SB_W    = 17;   // R0..R15 plus CPSR

    localparam logic [SB_W-1:0] SB_CPSR_BIT = 17'h1_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        READ  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Decode bundle as latched on acceptance
    typedef struct packed {
        logic [AW-1:0]     rn;
        logic [AW-1:0]     rm;
        logic [AW-1:0]     rs;
        logic              use_rn;
        logic              use_rm;
        logic              use_rs;
        logic [AW-1:0]     rd;
        logic              wr_rd;
        logic              rd_cpsr;
        logic              wr_cpsr;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    // One-hot scoreboard mask for register r, or zero when not enabled
    function automatic logic [SB_W-1:0] reg_bit(input logic [AW-1:0] r, input logic en);
        reg_bit = '0;
        if (en) reg_bit[r] = 1'b1;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy vector for R0..R15 and CPSR: one set mask, two register clears, one CPSR clear.
// Latency: set/clear visible one cycle after the request; hazard is combinational on the registered vector.
// Backpressure: none; set wins over clear on the same bit in the same cycle.
module operand_fetch_reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [SB_W-1:0] set_mask,
    input  logic            clr_en_1,
    input  logic [AW-1:0]   clr_addr_1,
    input  logic            clr_en_2,
    input  logic [AW-1:0]   clr_addr_2,
    input  logic            clr_cpsr,
    input  logic [SB_W-1:0] query_mask,
    output logic [SB_W-1:0] busy,
    output logic            hazard
);

    logic [SB_W-1:0] clr_mask;

    // Combine all retire requests; both ports may name the same register
    always_comb begin
        clr_mask = reg_bit(clr_addr_1, clr_en_1)
                 | reg_bit(clr_addr_2, clr_en_2)
                 | (clr_cpsr ? SB_CPSR_BIT : '0);
    end

    // Busy vector update: clear first, then set so a same-cycle set survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

    // Hazard looks only at the registered vector, so a clear helps one cycle later
    always_comb begin
        hazard = |(busy & query_mask);
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: hazard-check a decoded instruction, read the register file, present operands to execute.
// Latency: accept edge + 2 edges to op_valid with no hazard; one instruction per 4 cycles at best.
// Backpressure: in_ready only in IDLE; op bundle held stable until op_ready; flush returns to IDLE.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rn,
    input  logic [AW-1:0]     in_rm,
    input  logic [AW-1:0]     in_rs,
    input  logic              in_use_rn,
    input  logic              in_use_rm,
    input  logic              in_use_rs,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_wr_rd,
    input  logic              in_rd_cpsr,
    input  logic              in_wr_cpsr,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [AW-1:0]     rf_addr_1,
    output logic [AW-1:0]     rf_addr_2,
    output logic [AW-1:0]     rf_addr_3,
    output logic              rf_ren_1,
    output logic              rf_ren_2,
    output logic              rf_ren_3,
    input  logic [N-1:0]      rf_data_1,
    input  logic [N-1:0]      rf_data_2,
    input  logic [N-1:0]      rf_data_3,
    input  logic [N-1:0]      rf_cpsr,
    input  logic              clr_en_1,
    input  logic              clr_en_2,
    input  logic [AW-1:0]     clr_addr_1,
    input  logic [AW-1:0]     clr_addr_2,
    input  logic              clr_cpsr,
    input  logic              flush,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [N-1:0]      op_a,
    output logic [N-1:0]      op_b,
    output logic [N-1:0]      op_c,
    output logic [N-1:0]      op_cpsr,
    output logic [AW-1:0]     op_rd,
    output logic              op_wr_rd,
    output logic              op_wr_cpsr,
    output logic [CTRL_W-1:0] op_ctrl,
    output logic [SB_W-1:0]   sb_busy
);

    state_t          state, state_nxt;
    bundle_t         in_bundle, lat;
    logic            hazard;
    logic [SB_W-1:0] query_mask;
    logic [SB_W-1:0] set_mask;

    assign in_bundle = '{rn: in_rn, rm: in_rm, rs: in_rs,
                         use_rn: in_use_rn, use_rm: in_use_rm, use_rs: in_use_rs,
                         rd: in_rd, wr_rd: in_wr_rd,
                         rd_cpsr: in_rd_cpsr, wr_cpsr: in_wr_cpsr, ctrl: in_ctrl};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every other event
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = CHECK;
                CHECK:   if (!hazard)  state_nxt = READ;
                READ:    state_nxt = OUT;
                OUT:     if (op_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: accept only when idle and out of reset, so reset shows all outputs low
    always_comb begin
        in_ready = (state == IDLE) && !rst;
    end

    // Sources, WAW destination and CPSR all gate progress out of CHECK
    always_comb begin
        query_mask = reg_bit(lat.rn, lat.use_rn)
                   | reg_bit(lat.rm, lat.use_rm)
                   | reg_bit(lat.rs, lat.use_rs)
                   | reg_bit(lat.rd, lat.wr_rd)
                   | ((lat.rd_cpsr || lat.wr_cpsr) ? SB_CPSR_BIT : '0);
    end

    // Destination marked busy as the operands are captured; a flush in READ cancels it
    always_comb begin
        set_mask = '0;
        if (state == READ && !flush)
            set_mask = reg_bit(lat.rd, lat.wr_rd) | (lat.wr_cpsr ? SB_CPSR_BIT : '0);
    end

    // Latch the decode bundle on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lat <= '0;
        else if (state == IDLE && in_valid && !flush)
            lat <= in_bundle;
    end

    // Register-file read request: one-cycle pulse issued once the hazard clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_addr_1 <= '0;
            rf_addr_2 <= '0;
            rf_addr_3 <= '0;
            rf_ren_1  <= 1'b0;
            rf_ren_2  <= 1'b0;
            rf_ren_3  <= 1'b0;
        end else if (flush) begin
            rf_ren_1  <= 1'b0;
            rf_ren_2  <= 1'b0;
            rf_ren_3  <= 1'b0;
        end else if (state == CHECK && !hazard) begin
            rf_addr_1 <= lat.rn;
            rf_addr_2 <= lat.rm;
            rf_addr_3 <= lat.rs;
            rf_ren_1  <= lat.use_rn;
            rf_ren_2  <= lat.use_rm;
            rf_ren_3  <= lat.use_rs;
        end else if (state == READ) begin
            rf_ren_1  <= 1'b0;
            rf_ren_2  <= 1'b0;
            rf_ren_3  <= 1'b0;
        end
    end

    // Operand bundle capture and handshake towards execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= '0;
            op_cpsr    <= '0;
            op_rd      <= '0;
            op_wr_rd   <= 1'b0;
            op_wr_cpsr <= 1'b0;
            op_ctrl    <= '0;
        end else if (flush) begin
            op_valid   <= 1'b0;
        end else if (state == READ) begin
            op_valid   <= 1'b1;
            op_a       <= lat.use_rn ? rf_data_1 : '0;
            op_b       <= lat.use_rm ? rf_data_2 : '0;
            op_c       <= lat.use_rs ? rf_data_3 : '0;
            op_cpsr    <= rf_cpsr;
            op_rd      <= lat.rd;
            op_wr_rd   <= lat.wr_rd;
            op_wr_cpsr <= lat.wr_cpsr;
            op_ctrl    <= lat.ctrl;
        end else if (state == OUT && op_ready) begin
            op_valid   <= 1'b0;
        end
    end

    operand_fetch_reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_mask   (set_mask),
        .clr_en_1   (clr_en_1),
        .clr_addr_1 (clr_addr_1),
        .clr_en_2   (clr_en_2),
        .clr_addr_2 (clr_addr_2),
        .clr_cpsr   (clr_cpsr),
        .query_mask (query_mask),
        .busy       (sb_busy),
        .hazard     (hazard)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small negedge-sampling register-file model.
// Latency: n/a.
// Backpressure: exercises op_ready stalls, scoreboard stalls and flush.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  in_rn, in_rm, in_rs, in_rd;
    logic        in_use_rn, in_use_rm, in_use_rs;
    logic        in_wr_rd, in_rd_cpsr, in_wr_cpsr;
    logic [15:0] in_ctrl;
    logic [3:0]  rf_addr_1, rf_addr_2, rf_addr_3;
    logic        rf_ren_1, rf_ren_2, rf_ren_3;
    logic [31:0] rf_data_1, rf_data_2, rf_data_3, rf_cpsr;
    logic        clr_en_1, clr_en_2, clr_cpsr;
    logic [3:0]  clr_addr_1, clr_addr_2;
    logic        flush;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b, op_c, op_cpsr;
    logic [3:0]  op_rd;
    logic        op_wr_rd, op_wr_cpsr;
    logic [15:0] op_ctrl;
    logic [16:0] sb_busy;

    logic [31:0] rf_mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rs(in_rs),
        .in_use_rn(in_use_rn), .in_use_rm(in_use_rm), .in_use_rs(in_use_rs),
        .in_rd(in_rd), .in_wr_rd(in_wr_rd),
        .in_rd_cpsr(in_rd_cpsr), .in_wr_cpsr(in_wr_cpsr), .in_ctrl(in_ctrl),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_addr_3(rf_addr_3),
        .rf_ren_1(rf_ren_1), .rf_ren_2(rf_ren_2), .rf_ren_3(rf_ren_3),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .rf_data_3(rf_data_3),
        .rf_cpsr(rf_cpsr),
        .clr_en_1(clr_en_1), .clr_en_2(clr_en_2),
        .clr_addr_1(clr_addr_1), .clr_addr_2(clr_addr_2), .clr_cpsr(clr_cpsr),
        .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_cpsr(op_cpsr),
        .op_rd(op_rd), .op_wr_rd(op_wr_rd), .op_wr_cpsr(op_wr_cpsr),
        .op_ctrl(op_ctrl), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    // Register file: samples its read ports on the negedge when enabled
    initial begin
        rf_data_1 = 32'hDEAD_0001;
        rf_data_2 = 32'hDEAD_0002;
        rf_data_3 = 32'hDEAD_0003;
        forever begin
            @(negedge clk);
            if (rf_ren_1) rf_data_1 = rf_mem[rf_addr_1];
            if (rf_ren_2) rf_data_2 = rf_mem[rf_addr_2];
            if (rf_ren_3) rf_data_3 = rf_mem[rf_addr_3];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle for a single accept edge; use_mask bits: 0=rn 1=rm 2=rs
    task automatic issue(input int rn, input int rm, input int rs, input int use_mask,
                         input int rd, input int wrd, input int rdc, input int wrc,
                         input int ctrl);
        in_rn      = 4'(rn);
        in_rm      = 4'(rm);
        in_rs      = 4'(rs);
        in_use_rn  = use_mask[0];
        in_use_rm  = use_mask[1];
        in_use_rs  = use_mask[2];
        in_rd      = 4'(rd);
        in_wr_rd   = wrd[0];
        in_rd_cpsr = rdc[0];
        in_wr_cpsr = wrc[0];
        in_ctrl    = 16'(ctrl);
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic retire_ack();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rn = 0; in_rm = 0; in_rs = 0; in_rd = 0;
        in_use_rn = 0; in_use_rm = 0; in_use_rs = 0;
        in_wr_rd = 0; in_rd_cpsr = 0; in_wr_cpsr = 0; in_ctrl = 0;
        clr_en_1 = 0; clr_en_2 = 0; clr_addr_1 = 0; clr_addr_2 = 0; clr_cpsr = 0;
        flush = 0; op_ready = 0;
        rf_cpsr = 32'h0000_000A;
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);

        // Reset state
        tick(); tick();
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sb_busy",  32'(sb_busy),  32'd0);
        check("rst_rf_ren_1", 32'(rf_ren_1), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // No hazard: rn=R2, rm=R3, rd=R4
        rf_mem[2] = 32'h11;
        rf_mem[3] = 32'h22;
        issue(2, 3, 7, 3, 4, 1, 0, 0, 16'hBEEF);
        check("nh_in_ready_check", 32'(in_ready), 32'd0);
        check("nh_ren1_check",     32'(rf_ren_1), 32'd0);
        tick();
        check("nh_ren1_read",  32'(rf_ren_1),  32'd1);
        check("nh_ren2_read",  32'(rf_ren_2),  32'd1);
        check("nh_ren3_read",  32'(rf_ren_3),  32'd0);
        check("nh_addr1",      32'(rf_addr_1), 32'd2);
        check("nh_addr2",      32'(rf_addr_2), 32'd3);
        check("nh_valid_read", 32'(op_valid),  32'd0);
        tick();
        check("nh_op_valid", 32'(op_valid), 32'd1);
        check("nh_op_a",     op_a,          32'h11);
        check("nh_op_b",     op_b,          32'h22);
        check("nh_op_c",     op_c,          32'h0);
        check("nh_op_rd",    32'(op_rd),    32'd4);
        check("nh_op_wr_rd", 32'(op_wr_rd), 32'd1);
        check("nh_op_ctrl",  32'(op_ctrl),  32'hBEEF);
        check("nh_sb_busy",  32'(sb_busy),  32'h10);
        check("nh_ren1_out", 32'(rf_ren_1), 32'd0);

        // Back-pressure: execute holds off for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_op_valid", 32'(op_valid), 32'd1);
            check("bp_op_a",     op_a,          32'h11);
            check("bp_op_b",     op_b,          32'h22);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        retire_ack();
        check("bp_done_valid", 32'(op_valid), 32'd0);
        check("bp_done_ready", 32'(in_ready), 32'd1);

        // RAW stall on R4 until writeback retires it
        rf_mem[4] = 32'h44;
        issue(4, 0, 0, 1, 5, 1, 0, 0, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("raw_stall_ren1",  32'(rf_ren_1), 32'd0);
            check("raw_stall_valid", 32'(op_valid), 32'd0);
            check("raw_stall_ready", 32'(in_ready), 32'd0);
        end
        rf_mem[4] = 32'h4444;
        clr_en_1 = 1'b1; clr_addr_1 = 4'd4;
        tick();
        clr_en_1 = 1'b0;
        check("raw_clr_sb",   32'(sb_busy),  32'h0);
        check("raw_clr_ren1", 32'(rf_ren_1), 32'd0);
        tick();
        check("raw_read_ren1",  32'(rf_ren_1),  32'd1);
        check("raw_read_addr1", 32'(rf_addr_1), 32'd4);
        tick();
        check("raw_op_valid", 32'(op_valid), 32'd1);
        check("raw_op_a",     op_a,          32'h4444);
        check("raw_sb_busy",  32'(sb_busy),  32'h20);
        retire_ack();

        // CPSR hazard: writer then reader
        issue(0, 0, 0, 0, 0, 0, 0, 1, 16'h0003);
        tick(); tick();
        check("cw_op_valid",   32'(op_valid),   32'd1);
        check("cw_op_wr_cpsr", 32'(op_wr_cpsr), 32'd1);
        check("cw_sb_busy",    32'(sb_busy),    32'h10020);
        retire_ack();
        issue(0, 0, 0, 0, 0, 0, 1, 0, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cr_stall_valid", 32'(op_valid), 32'd0);
        end
        rf_cpsr = 32'hC000_0000;
        clr_cpsr = 1'b1;
        tick();
        clr_cpsr = 1'b0;
        check("cr_clr_sb", 32'(sb_busy), 32'h20);
        tick(); tick();
        check("cr_op_valid", 32'(op_valid), 32'd1);
        check("cr_op_cpsr",  op_cpsr,       32'hC000_0000);
        retire_ack();

        // Flush while in READ: no output, no scoreboard set for R6
        issue(2, 0, 0, 1, 6, 1, 0, 0, 16'h0005);
        tick();
        check("fl_ren1_read", 32'(rf_ren_1), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_op_valid", 32'(op_valid), 32'd0);
        check("fl_ren1",     32'(rf_ren_1), 32'd0);
        check("fl_sb_busy",  32'(sb_busy),  32'h20);
        tick();
        check("fl_op_valid_after", 32'(op_valid), 32'd0);

        // Same-cycle set and clear on R5: set wins
        clr_en_1 = 1'b1; clr_addr_1 = 4'd5;
        tick();
        clr_en_1 = 1'b0;
        check("sc_pre_sb", 32'(sb_busy), 32'h0);
        issue(0, 0, 0, 0, 5, 1, 0, 0, 16'h0006);
        tick();
        clr_en_2 = 1'b1; clr_addr_2 = 4'd5;
        tick();
        clr_en_2 = 1'b0;
        check("sc_sb_busy",  32'(sb_busy),  32'h20);
        check("sc_op_valid", 32'(op_valid), 32'd1);
        retire_ack();

        // WAW stall on R5, released by both clear ports naming R5
        issue(0, 0, 0, 0, 5, 1, 0, 0, 16'h0007);
        tick(); tick();
        check("waw_stall_valid", 32'(op_valid), 32'd0);
        check("waw_stall_ren",   32'(rf_ren_1), 32'd0);
        clr_en_1 = 1'b1; clr_addr_1 = 4'd5;
        clr_en_2 = 1'b1; clr_addr_2 = 4'd5;
        tick();
        clr_en_1 = 1'b0; clr_en_2 = 1'b0;
        check("waw_clr_sb", 32'(sb_busy), 32'h0);
        tick(); tick();
        check("waw_op_valid", 32'(op_valid), 32'd1);
        check("waw_sb_busy",  32'(sb_busy),  32'h20);
        retire_ack();

        // Reset while stalled in CHECK with only R4 busy
        clr_en_1 = 1'b1; clr_addr_1 = 4'd5;
        tick();
        clr_en_1 = 1'b0;
        issue(0, 0, 0, 0, 4, 1, 0, 0, 16'h0008);
        tick(); tick();
        check("mr_writer_cpsr", op_cpsr, 32'hC000_0000);
        retire_ack();
        check("mr_pre_sb", 32'(sb_busy), 32'h10);
        issue(4, 0, 0, 1, 9, 1, 0, 0, 16'h0009);
        tick();
        check("mr_stall_ready", 32'(in_ready), 32'd0);
        check("mr_stall_ren1",  32'(rf_ren_1), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mr_sb_busy",  32'(sb_busy),  32'h0);
        check("mr_op_cpsr",  op_cpsr,       32'h0);
        check("mr_op_rd",    32'(op_rd),    32'd0);
        check("mr_op_wr_rd", 32'(op_wr_rd), 32'd0);
        check("mr_op_ctrl",  32'(op_ctrl),  32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("mr_after_ready", 32'(in_ready), 32'd1);
        check("mr_after_valid", 32'(op_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
